grf_wb_arbiter: RTL and testbench

- Shares the single GRF write port between two writeback requesters: port 0 (main pipeline writeback) and port 1 (long-latency unit, e.g. multiply/divide or memory return).
- Registers the winning write into an output stage that drives GRF WE/A3/WD3/PC.
- Keeps a 32-entry pending scoreboard of registers owed by port 1 and reports busy status, so decode can stall reads of in-flight registers.

---
 rtl/grf_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_grf_wb_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter.sv
// Two-port writeback arbiter for the single GRF write port, with a
// pending-register scoreboard for the long-latency port.
module grf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned CNT_W        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb0_valid,
  output logic        wb0_ready,
  input  logic [4:0]  wb0_a3,
  input  logic [31:0] wb0_wd,
  input  logic [31:0] wb0_pc,
  input  logic        wb1_valid,
  output logic        wb1_ready,
  input  logic [4:0]  wb1_a3,
  input  logic [31:0] wb1_wd,
  input  logic [31:0] wb1_pc,
  input  logic        iss_valid,
  input  logic [4:0]  iss_a3,
  input  logic [4:0]  q_a1,
  input  logic [4:0]  q_a2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        pend_any,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wb_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_q, pend_d;
  logic             we_q, we_d;
  wb_t              out_q, out_d;

  logic             boost;
  logic             rdy0, rdy1;
  logic             hs0, hs1;
  logic             busy1, busy2;
  wb_t              win;

  assign boost = 32'(cnt_q) >= 32'(STARVE_LIMIT);
  assign rdy0  = !(wb1_valid && boost);
  assign rdy1  = !wb0_valid || boost;
  assign hs0   = wb0_valid && rdy0;
  assign hs1   = wb1_valid && rdy1;

  always_comb begin
    win = '0;
    unique case (1'b1)
      hs1:     win = '{a3: wb1_a3, wd: wb1_wd, pc: wb1_pc};
      hs0:     win = '{a3: wb0_a3, wd: wb0_wd, pc: wb0_pc};
      default: win = '0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!wb1_valid || hs1) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A write to $0 still refreshes the address/data/pc registers.
  always_comb begin
    we_d  = 1'b0;
    out_d = out_q;
    if (hs0 || hs1) begin
      we_d  = (win.a3 != 5'd0);
      out_d = win;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    pend_d = pend_q;
    if (hs1) begin
      pend_d[wb1_a3] = 1'b0;
    end
    if (iss_valid && iss_a3 != 5'd0) begin
      pend_d[iss_a3] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      pend_q <= '0;
      we_q   <= 1'b0;
      out_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      we_q   <= we_d;
      out_q  <= out_d;
    end
  end

  // The in-flight output stage counts as busy until the GRF commits it.
  assign busy1 = (q_a1 != 5'd0) &&
                 (pend_q[q_a1] || (we_q && out_q.a3 == q_a1));
  assign busy2 = (q_a2 != 5'd0) &&
                 (pend_q[q_a2] || (we_q && out_q.a3 == q_a2));

  assign wb0_ready = reset && rdy0;
  assign wb1_ready = reset && rdy1;
  assign q_busy1   = reset && busy1;
  assign q_busy2   = reset && busy2;
  assign pend_any  = reset && (|pend_q);

  assign grf_we = we_q;
  assign grf_a3 = out_q.a3;
  assign grf_wd = out_q.wd;
  assign grf_pc = out_q.pc;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: reset, single write, starvation,
// scoreboard, same-cycle set/clear and $0 writes.
module tb_grf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        wb0_valid, wb0_ready;
  logic [4:0]  wb0_a3;
  logic [31:0] wb0_wd, wb0_pc;
  logic        wb1_valid, wb1_ready;
  logic [4:0]  wb1_a3;
  logic [31:0] wb1_wd, wb1_pc;
  logic        iss_valid;
  logic [4:0]  iss_a3;
  logic [4:0]  q_a1, q_a2;
  logic        q_busy1, q_busy2, pend_any;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;

  int n_cmp;
  int n_bad;

  grf_wb_arbiter #(.STARVE_LIMIT(3), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready),
    .wb0_a3(wb0_a3), .wb0_wd(wb0_wd), .wb0_pc(wb0_pc),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready),
    .wb1_a3(wb1_a3), .wb1_wd(wb1_wd), .wb1_pc(wb1_pc),
    .iss_valid(iss_valid), .iss_a3(iss_a3),
    .q_a1(q_a1), .q_a2(q_a2),
    .q_busy1(q_busy1), .q_busy2(q_busy2), .pend_any(pend_any),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] p1_win;
    n_cmp = 0;
    n_bad = 0;
    p1_win = 6'b001000;
    reset = 1'b0;
    wb0_valid = 0; wb0_a3 = 0; wb0_wd = 0; wb0_pc = 0;
    wb1_valid = 0; wb1_a3 = 0; wb1_wd = 0; wb1_pc = 0;
    iss_valid = 0; iss_a3 = 0; q_a1 = 0; q_a2 = 0;
    #3;
    chk("rst_we", grf_we, 0);
    chk("rst_a3", grf_a3, 0);
    chk("rst_rdy0", wb0_ready, 0);
    chk("rst_rdy1", wb1_ready, 0);
    chk("rst_pend", pend_any, 0);
    tick();
    tick();
    reset = 1'b1;

    // reset during a port 0 handshake
    wb0_valid = 1; wb0_a3 = 5; wb0_wd = 32'h1234; wb0_pc = 32'h100;
    #1;
    chk("mid_rdy0", wb0_ready, 1);
    reset = 1'b0;
    #1;
    chk("mid_we", grf_we, 0);
    chk("mid_rdy0_rst", wb0_ready, 0);
    chk("mid_pend", pend_any, 0);
    wb0_valid = 0;
    tick();
    reset = 1'b1;
    tick();
    chk("mid_after_we", grf_we, 0);
    chk("mid_after_wd", grf_wd, 0);

    // single port 0 write
    wb0_valid = 1; wb0_a3 = 8; wb0_wd = 32'hDEADBEEF; wb0_pc = 32'h3000;
    #1;
    chk("sw_rdy0", wb0_ready, 1);
    tick();
    wb0_valid = 0;
    chk("sw_we", grf_we, 1);
    chk("sw_a3", grf_a3, 8);
    chk("sw_wd", grf_wd, 32'hDEADBEEF);
    chk("sw_pc", grf_pc, 32'h3000);
    tick();
    chk("sw_we_off", grf_we, 0);
    chk("sw_a3_hold", grf_a3, 8);

    // both ports contend for six cycles
    wb0_valid = 1; wb0_a3 = 1; wb0_wd = 32'hA0; wb0_pc = 32'h10;
    wb1_valid = 1; wb1_a3 = 2; wb1_wd = 32'hB1; wb1_pc = 32'h20;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("st%0d_rdy0", i), wb0_ready, !p1_win[i]);
      chk($sformatf("st%0d_rdy1", i), wb1_ready, p1_win[i]);
      tick();
      chk($sformatf("st%0d_a3", i), grf_a3, p1_win[i] ? 2 : 1);
      chk($sformatf("st%0d_wd", i), grf_wd, p1_win[i] ? 32'hB1 : 32'hA0);
    end
    wb0_valid = 0; wb1_valid = 0;
    tick();
    chk("st_we_off", grf_we, 0);

    // scoreboard on reg 9
    iss_valid = 1; iss_a3 = 9; q_a1 = 9;
    #1;
    chk("sb_busy_pre", q_busy1, 0);
    tick();
    iss_valid = 0;
    chk("sb_pend_any", pend_any, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sb_busy%0d", i), q_busy1, 1);
      tick();
    end
    wb1_valid = 1; wb1_a3 = 9; wb1_wd = 32'h99; wb1_pc = 32'h44;
    #1;
    chk("sb_rdy1", wb1_ready, 1);
    chk("sb_busy_hs", q_busy1, 1);
    tick();
    wb1_valid = 0;
    chk("sb_we", grf_we, 1);
    chk("sb_a3", grf_a3, 9);
    chk("sb_busy_out", q_busy1, 1);
    chk("sb_pend_clr", pend_any, 0);
    tick();
    chk("sb_busy_done", q_busy1, 0);

    // same-cycle set and clear on reg 12
    q_a2 = 12;
    iss_valid = 1; iss_a3 = 12;
    tick();
    chk("sc_busy_set", q_busy2, 1);
    wb1_valid = 1; wb1_a3 = 12; wb1_wd = 32'hC12; wb1_pc = 32'h50;
    tick();
    iss_valid = 0; wb1_valid = 0;
    chk("sc_we", grf_we, 1);
    tick();
    chk("sc_we_off", grf_we, 0);
    chk("sc_busy_keep", q_busy2, 1);
    chk("sc_pend_keep", pend_any, 1);
    wb1_valid = 1;
    tick();
    wb1_valid = 0;
    chk("sc_pend_clr", pend_any, 0);
    tick();
    chk("sc_busy_clr", q_busy2, 0);

    // port 1 write to $0 plus an issue to $0
    q_a1 = 0;
    iss_valid = 1; iss_a3 = 0;
    wb1_valid = 1; wb1_a3 = 0; wb1_wd = 32'hFFFF; wb1_pc = 32'h60;
    #1;
    chk("z_rdy1", wb1_ready, 1);
    chk("z_busy_pre", q_busy1, 0);
    tick();
    wb1_valid = 0; iss_valid = 0;
    chk("z_we", grf_we, 0);
    chk("z_a3", grf_a3, 0);
    chk("z_wd", grf_wd, 32'hFFFF);
    chk("z_pc", grf_pc, 32'h60);
    chk("z_busy", q_busy1, 0);
    chk("z_pend", pend_any, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
